rns2bin_mrc: RTL and testbench
==============================

# rns2bin_mrc

Iterative residue-to-binary converter that reconstructs a signed two's-complement integer from four residues using mixed-radix conversion (MRC). It sits directly downstream of the binary-to-RNS LUT converter and consumes its four residue outputs. It closes the BIN2RNS → RNS → RNS2BIN loop for the default moduli set {8, 7, 5, 3}: M = 840, signed dynamic range −420…419.

## Interface

Parameters:
- WIDTH, 32, bit width of the reconstructed binary output
- MOD_SIZE, 3, bit width of each residue input
- M1, 8, modulus of residue 1 (first MRC radix)
- M2, 7, modulus of residue 2
- M3, 5, modulus of residue 3
- M4, 3, modulus of residue 4
- Constraints: moduli pairwise coprime; each Mi ≤ 2^MOD_SIZE; M1·M2·M3·M4 < 2^(WIDTH−1)
- Modular inverses are constant functions of the moduli, evaluated at elaboration

Ports:
- clk, in, 1, single clock; all state updates on rising edge
- reset, in, 1, synchronous, active-low; sampled on rising edge of clk
- in_valid, in, 1, residue tuple valid
- in_ready, out, 1, block can accept a tuple
- res_1 … res_4, in, MOD_SIZE each, residues modulo M1…M4
- out_valid, out, 1, out_bin/out_err valid
- out_ready, in, 1, downstream accepts result
- out_bin, out, WIDTH, signed two's-complement result
- out_err, out, 1, input tuple contained a residue ≥ its modulus

## Operation

- FSM states: IDLE → DIGIT (3 cycles, counter k = 1..3) → SUM → OUT → IDLE.
- IDLE: in_ready = 1. On in_valid && in_ready, register res_1..res_4 into r1..r4. Set err = (res_i ≥ Mi for any i). Go to DIGIT with k = 1.
- DIGIT step k: latch digit a_k = r_k. For every j > k, update r_j ← ((r_j + Mj·Mk − a_k) · inv(Mk mod Mj)) mod Mj.
  - Intermediates are never negative.
  - Width is sized to hold (Mj + Mj·Mk)·Mj without overflow.
- After k = 3: a4 = r4. Go to SUM.
- SUM: X = a1 + a2·M1 + a3·M1·M2 + a4·M1·M2·M3, so 0 ≤ X < M.
  - If X ≥ M/2 (floor for odd M): out_bin ← X − M, sign-extended to WIDTH. Otherwise out_bin ← X.
  - If err is set: out_bin ← 0, out_err ← 1.
  - Go to OUT.
- OUT: out_valid = 1. out_bin and out_err are held stable until out_valid && out_ready at a rising edge, then go to IDLE.
- in_ready = 0 in every state except IDLE. There is no input overlap.
- Reset (reset = 0 at an edge), from any state including mid-DIGIT or OUT: go to IDLE and clear r1..r4, digits, and k. Any in-flight conversion is discarded and produces no output.

## Timing

- Reset values: in_ready = 0 during the reset cycle, 1 on the first edge with reset = 1. out_valid = 0, out_bin = 0, out_err = 0.
- Acceptance edge E0. DIGIT occupies edges E1–E3, SUM executes on E4, out_valid = 1 starting after E4. Latency is 4 cycles from acceptance to valid.
- With out_ready held at 1: OUT lasts 1 cycle, IDLE lasts 1 cycle. Throughput is one tuple per 6 cycles.
- Backpressure: out_valid stays 1 and outputs do not change while out_ready = 0, for any duration.
- in_valid while not in IDLE: ignored. The upstream must hold its data until in_ready.
- out_ready while out_valid = 0: ignored.
- Reset asserted in the same cycle as an accept or an output handshake: reset wins. The tuple is dropped, or the result is lost.

## Test plan

- Residues (0,0,0,0) accepted → out_valid exactly 4 cycles later, out_bin = 0x00000000, out_err = 0.
- Residues (3,6,4,2) → out_bin = 419 (0x000001A3). Residues (4,0,0,0) → out_bin = −420 (0xFFFFFE5C), exercising the sign threshold at X = 420.
- Residues (7,6,4,2), i.e. X = 839 → out_bin = 0xFFFFFFFF (−1). Sweep all n in −420…419 through the upstream converter into this block; every out_bin must equal n.
- Residues (0,7,0,0), residue 2 ≥ 7 → out_err = 1, out_bin = 0. The next valid tuple (1,1,1,1) → out_bin = 1, out_err = 0.
- Backpressure: hold out_ready = 0 for 10 cycles with result 419 → out_valid and out_bin stay constant and in_ready = 0 throughout. Raise out_ready → one handshake, then in_ready = 1 the next cycle.
- Reset pulled low during DIGIT k = 2 → next cycle in IDLE with out_valid = 0 and no result emitted. A fresh tuple (3,6,4,2) then converts to 419 with normal latency.

Source files
------------

// File: rtl/rns2bin_mrc.sv
// Mixed-radix residue-to-binary converter for a four-modulus RNS.
// Output is the signed value centred on zero.
module rns2bin_mrc #(
    parameter int WIDTH    = 32,
    parameter int MOD_SIZE = 3,
    parameter int M1       = 8,
    parameter int M2       = 7,
    parameter int M3       = 5,
    parameter int M4       = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MOD_SIZE-1:0] res_1,
    input  logic [MOD_SIZE-1:0] res_2,
    input  logic [MOD_SIZE-1:0] res_3,
    input  logic [MOD_SIZE-1:0] res_4,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_bin,
    output logic                out_err
);

    function automatic int mod_inv(input int a, input int m);
        int r;
        r = 0;
        for (int x = 1; x < m; x++) begin
            if (r == 0 && ((a * x) % m) == 1) r = x;
        end
        return r;
    endfunction

    localparam int INV12   = mod_inv(M1 % M2, M2);
    localparam int INV13   = mod_inv(M1 % M3, M3);
    localparam int INV14   = mod_inv(M1 % M4, M4);
    localparam int INV23   = mod_inv(M2 % M3, M3);
    localparam int INV24   = mod_inv(M2 % M4, M4);
    localparam int INV34   = mod_inv(M3 % M4, M4);
    localparam int M_TOTAL = M1 * M2 * M3 * M4;
    localparam int HALF    = M_TOTAL / 2;

    // Adding Mj*Mk before subtracting the digit keeps the intermediate non-negative.
    function automatic logic [MOD_SIZE-1:0] mrc_step(
        input logic [MOD_SIZE-1:0] rj,
        input logic [MOD_SIZE-1:0] ak,
        input int                  mj,
        input int                  mk,
        input int                  inv
    );
        int t;
        t = (int'(rj) + mj * mk - int'(ak)) * inv;
        return MOD_SIZE'(t % mj);
    endfunction

    typedef enum logic [1:0] {IDLE, DIGIT, SUM, OUT} state_t;

    state_t              state;
    state_t              next_state;
    logic [1:0]          k;
    logic [MOD_SIZE-1:0] r1, r2, r3, r4;
    logic [MOD_SIZE-1:0] a1, a2, a3;
    logic                err;
    logic                armed;
    logic [WIDTH-1:0]    x;
    logic [WIDTH-1:0]    x_signed;
    logic                accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = DIGIT;
            DIGIT:   if (k == 2'd3) next_state = SUM;
            SUM:     next_state = OUT;
            OUT:     if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // in_ready stays low until the first edge after reset is released.
    always_comb begin
        in_ready  = (state == IDLE) && armed;
        out_valid = (state == OUT);
    end

    // r4 already holds the final digit a4 once the third step has run.
    always_comb begin
        x = WIDTH'(a1)
          + WIDTH'(a2) * WIDTH'(M1)
          + WIDTH'(a3) * WIDTH'(M1 * M2)
          + WIDTH'(r4) * WIDTH'(M1 * M2 * M3);
        x_signed = (x >= WIDTH'(HALF)) ? (x - WIDTH'(M_TOTAL)) : x;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            armed   <= 1'b0;
            k       <= 2'd0;
            r1      <= '0;
            r2      <= '0;
            r3      <= '0;
            r4      <= '0;
            a1      <= '0;
            a2      <= '0;
            a3      <= '0;
            err     <= 1'b0;
            out_bin <= '0;
            out_err <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        r1  <= res_1;
                        r2  <= res_2;
                        r3  <= res_3;
                        r4  <= res_4;
                        err <= (int'(res_1) >= M1) || (int'(res_2) >= M2) ||
                               (int'(res_3) >= M3) || (int'(res_4) >= M4);
                        k   <= 2'd1;
                    end
                end
                DIGIT: begin
                    case (k)
                        2'd1: begin
                            a1 <= r1;
                            r2 <= mrc_step(r2, r1, M2, M1, INV12);
                            r3 <= mrc_step(r3, r1, M3, M1, INV13);
                            r4 <= mrc_step(r4, r1, M4, M1, INV14);
                            k  <= 2'd2;
                        end
                        2'd2: begin
                            a2 <= r2;
                            r3 <= mrc_step(r3, r2, M3, M2, INV23);
                            r4 <= mrc_step(r4, r2, M4, M2, INV24);
                            k  <= 2'd3;
                        end
                        default: begin
                            a3 <= r3;
                            r4 <= mrc_step(r4, r3, M4, M3, INV34);
                            k  <= 2'd0;
                        end
                    endcase
                end
                SUM: begin
                    out_bin <= err ? '0 : x_signed;
                    out_err <= err;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rns2bin_mrc.sv
// Scoreboard bench for rns2bin_mrc: directed vectors plus a full-range sweep,
// with a decoupled monitor checking value, error flag and latency.
module tb_rns2bin_mrc;

    localparam int WIDTH    = 32;
    localparam int MOD_SIZE = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [MOD_SIZE-1:0] res_1, res_2, res_3, res_4;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_bin;
    logic                out_err;

    rns2bin_mrc #(
        .WIDTH(WIDTH), .MOD_SIZE(MOD_SIZE), .M1(8), .M2(7), .M3(5), .M4(3)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .res_1(res_1), .res_2(res_2), .res_3(res_3), .res_4(res_4),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   bin;
        logic err;
        int   acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle      = 0;
    int   last_acc   = 0;
    bit   prev_valid = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int v1, input int v2, input int v3, input int v4,
                                 input int exp_bin, input logic exp_err, input bit track);
        int   waited;
        exp_t e;
        @(negedge clk);
        res_1    = MOD_SIZE'(v1);
        res_2    = MOD_SIZE'(v2);
        res_3    = MOD_SIZE'(v3);
        res_4    = MOD_SIZE'(v4);
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
        end else begin
            e.bin    = exp_bin;
            e.err    = exp_err;
            e.acc    = cycle + 1;
            last_acc = cycle + 1;
            if (track) sb.push_back(e);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while (sb.size() > 0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain_pending", sb.size(), 0);
    endtask

    function automatic int pmod(input int n, input int m);
        return ((n % m) + m) % m;
    endfunction

    // Monitor: latency on each new result, value/flag on each handshake.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) checkOutput("unexpected_output", out_valid, 0);
                else                checkOutput("latency", cycle - sb[0].acc, 4);
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                mon_e = sb.pop_front();
                checkOutput("out_bin", $signed(out_bin), mon_e.bin);
                checkOutput("out_err", out_err, mon_e.err);
            end
            prev_valid = out_valid;
        end
    end

    int vec[8][5] = '{
        '{0, 0, 0, 0, 0},
        '{3, 6, 4, 2, 419},
        '{4, 0, 0, 0, -420},
        '{7, 6, 4, 2, -1},
        '{1, 1, 1, 1, 1},
        '{4, 2, 0, 1, 100},
        '{4, 5, 0, 2, -100},
        '{5, 4, 2, 0, -3}
    };

    initial begin
        int waited;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        res_1 = '0; res_2 = '0; res_3 = '0; res_4 = '0;

        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_bin", out_bin, 0);
        checkOutput("rst_out_err", out_err, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 checkOutput("ready_after_rst", in_ready, 1);

        for (int i = 0; i < 8; i++)
            applyStimulus(vec[i][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4], 1'b0, 1'b1);
        waitDrain();

        applyStimulus(0, 7, 0, 0, 0, 1'b1, 1'b1);
        applyStimulus(1, 1, 1, 1, 1, 1'b0, 1'b1);
        waitDrain();

        // Backpressure: result must freeze while downstream stalls.
        out_ready = 1'b0;
        applyStimulus(3, 6, 4, 2, 419, 1'b0, 1'b1);
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_out_bin", $signed(out_bin), 419);
            checkOutput("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_ready_after", in_ready, 1);
        checkOutput("bp_valid_after", out_valid, 0);
        waitDrain();

        // Reset while the second digit step is pending drops the tuple.
        applyStimulus(3, 6, 4, 2, 0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        applyStimulus(3, 6, 4, 2, 419, 1'b0, 1'b1);
        waitDrain();

        for (int n = -420; n <= 419; n++) begin
            int prev;
            prev = last_acc;
            applyStimulus(pmod(n, 8), pmod(n, 7), pmod(n, 5), pmod(n, 3), n, 1'b0, 1'b1);
            if (n > -420) checkOutput("throughput", last_acc - prev, 6);
        end
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
